// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq
//   Sequential AES InvSubBytes. A 128-bit state is accepted over a
//   valid/ready handshake. LANES bytes are replaced by their inverse S-box
//   value on each cycle, so one block takes N = 16/LANES cycles. The result
//   is then held until downstream accepts it.
//
//   Optional build macro INV_SBOX_FAULT_CHECK_EN:
//     Each lane's result is mapped back through a forward S-box and compared
//     against the original byte. Any mismatch sets a sticky per-block fault
//     flag. Without the macro, fault is constant 0. Data timing is the same
//     in both builds.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   state_in valid
//   in_ready   block idle and able to accept
//   state_in   input state; byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  state_out / fault valid
//   out_ready  downstream accepts result
//   state_out  substituted state, same byte order
//   fault      fault flag, qualified by out_valid
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         fault
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   w_q, w_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fault_q, fault_d;

  logic [3:0]             base;
  logic [LANES-1:0][3:0]  lane_idx;
  logic [8*LANES-1:0]     old_bytes;
  logic [8*LANES-1:0]     sub_bytes;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1 for a != 0. The product is naturally 0 for a == 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Undo the forward affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

`ifdef INV_SBOX_FAULT_CHECK_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  logic [LANES-1:0] lane_err;
`endif

  // First byte index of the current chunk. With LANES=16 the product
  // truncates to 0, which is correct because cnt is always 0.
  assign base = 4'(cnt_q) * 4'(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = base + 4'(gi);
    // Byte k lives at bit offset 8*(15-k); for a 4-bit k, 15-k == ~k
    assign old_bytes[8*gi +: 8] = w_q[{~lane_idx[gi], 3'b000} +: 8];
    assign sub_bytes[8*gi +: 8] = inv_sbox(old_bytes[8*gi +: 8]);
`ifdef INV_SBOX_FAULT_CHECK_EN
    assign lane_err[gi] = (fwd_sbox(sub_bytes[8*gi +: 8]) != old_bytes[8*gi +: 8]);
`endif
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d     = state_in;
          cnt_d   = '0;
          fault_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          w_d[{~lane_idx[l], 3'b000} +: 8] = sub_bytes[8*l +: 8];
        end
`ifdef INV_SBOX_FAULT_CHECK_EN
        fault_d = fault_q | (|lane_err);
`endif
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // All handshake outputs decode registered state only
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign state_out = w_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;
  logic         fault;

  logic [2:0]   x_in_ready, x_out_valid, x_fault;
  logic [127:0] x_state_out [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] inv_tbl [256];

  localparam logic [127:0] V1_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V1_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .fault(fault)
  );

  // Extra instances for the LANES sweep; they share all inputs
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int LV = (gi == 0) ? 1 : ((gi == 1) ? 2 : 16);
    inv_sub_bytes_seq #(.LANES(LV)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready[gi]),
      .state_in(state_in), .out_valid(x_out_valid[gi]), .out_ready(out_ready),
      .state_out(x_state_out[gi]), .fault(x_fault[gi])
    );
  end

  // Reference: plain field arithmetic, inverse found by search, forward
  // S-box tabulated and then inverted as a permutation.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(acc);
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      r = inv;
      for (int k = 0; k < 5; k++) begin
        s = s ^ r;
        r = {r[6:0], r[7]};
      end
      inv_tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] d);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_tbl[d[8*i +: 8]];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the LANES=4 instance with random output stall
  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] exp,
                           input logic exp_fault);
    int lat;
    check({tag, ".in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    state_in = d;
    tick();
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 128'(lat), 128'(4));
    check({tag, ".data"}, state_out, exp);
    check({tag, ".fault"}, 128'(fault), 128'(exp_fault));
    repeat ($urandom_range(0, 3)) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".back_idle"}, 128'({in_ready, out_valid}), 128'(2'b10));
    $display("block %s in=%h out=%h latency=%0d", tag, d, exp, lat);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d, exp;
    int lats[4];
    int exp_lat[4];

    build_model();
    tick();
    tick();
    rst = 1'b0;
    check("reset.in_ready", 128'(in_ready), 128'(1));
    check("reset.out_valid", 128'(out_valid), 128'(0));
    check("reset.state_out", state_out, 128'(0));
    check("reset.fault", 128'(fault), 128'(0));

    run_block("vec1", V1_IN, V1_OUT, 1'b0);
    run_block("all00", {16{8'h00}}, {16{8'h52}}, 1'b0);
    run_block("all16", {16{8'h16}}, {16{8'hff}}, 1'b0);
    run_block("alled", {16{8'hed}}, {16{8'h53}}, 1'b0);
    for (int i = 0; i < 12; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rand%0d", i), d, ref_block(d), 1'b0);
    end

    // Backpressure: hold result for 10 cycles while junk in_valid arrives
    d = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_block(d);
    in_valid = 1'b1;
    state_in = d;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("bp.out_valid", 128'(out_valid), 128'(1));
      check("bp.in_ready", 128'(in_ready), 128'(0));
      check("bp.state_out", state_out, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release", 128'({in_ready, out_valid}), 128'(2'b10));
    tick();
    check("bp.no_accept", 128'(in_ready), 128'(1));
    $display("backpressure block out=%h", exp);

    // Reset during the second BUSY cycle
    in_valid = 1'b1;
    state_in = V1_IN;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.out_valid", 128'(out_valid), 128'(0));
    check("midrst.state_out", state_out, 128'(0));
    check("midrst.in_ready", 128'(in_ready), 128'(1));
    check("midrst.fault", 128'(fault), 128'(0));
    run_block("after_rst", V1_IN, V1_OUT, 1'b0);

    // LANES sweep: 1, 2, 16 (plus the main LANES=4 instance)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    state_in = V1_IN;
    tick();
    in_valid = 1'b0;
    lats = '{0, 0, 0, 0};
    exp_lat = '{16, 8, 1, 4};
    for (int t = 1; t <= 20; t++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (x_out_valid[i] && lats[i] == 0) lats[i] = t;
      if (out_valid && lats[3] == 0) lats[3] = t;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sweep%0d.latency", i), 128'(lats[i]), 128'(exp_lat[i]));
      check($sformatf("sweep%0d.data", i), x_state_out[i], V1_OUT);
      $display("sweep inst=%0d latency=%0d out=%h", i, lats[i], x_state_out[i]);
    end
    check("sweep4.latency", 128'(lats[3]), 128'(exp_lat[3]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sweep.back_idle", 128'({x_in_ready, in_ready}), 128'(4'b1111));

`ifdef INV_SBOX_FAULT_CHECK_EN
    // Corrupt lane outputs for one BUSY cycle; fault must be raised
    in_valid = 1'b1;
    state_in = '0;
    tick();
    in_valid = 1'b0;
    force dut.sub_bytes = '0;
    tick();
    release dut.sub_bytes;
    repeat (4) tick();
    check("fault.out_valid", 128'(out_valid), 128'(1));
    check("fault.flag", 128'(fault), 128'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_block("fault_clean", V1_IN, V1_OUT, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential AES InvSubBytes unit for the decryption datapath: accepts a 128-bit cipher state over a valid/ready handshake and replaces every byte with its inverse S-box value, LANES bytes per cycle. It is the decrypt-side counterpart of the byte S-box lookup used by encryption. It sits between InvShiftRows and AddRoundKey in the inverse round. An optional fault-protection path re-encrypts each result byte through the forward S-box and flags any mismatch.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; N = 16/LANES cycles per block.
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in valid.
- in_ready  output  1  block can accept; high only in IDLE.
- state_in  input  128  state; byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  state_out/fault valid; high only in DONE.
- out_ready  input  1  downstream accepts.
- state_out  output  128  substituted state, same byte order.
- fault  output  1  per-block fault flag, qualified by out_valid; tied 0 when protection is compiled out.

## Operation
- Per-byte function: InvSbox(a) = GFinv(A(a)).
  - A(a) = rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 8'h05.
  - GFinv is the multiplicative inverse mod x^8+x^4+x^3+x+1, with GFinv(0)=0.
  - Implementation may use a 256-entry table or a composite-field circuit; results must be bit-exact.
- FSM states IDLE, BUSY, DONE; 128-bit working register W; chunk counter cnt of width clog2(N) (1 bit minimum).
- IDLE:
  - in_ready=1.
  - On in_valid: W<=state_in, cnt<=0, fault<=0, go to BUSY.
- BUSY:
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of W are replaced by InvSbox of themselves.
  - cnt increments each cycle.
  - After processing chunk N-1, go to DONE. cnt wraps to 0 and is never read outside BUSY.
- DONE:
  - out_valid=1; state_out=W.
  - On out_ready, go to IDLE.
  - Holds state_out and fault stable indefinitely while out_ready=0 (backpressure).
- in_ready is deasserted in BUSY and DONE. in_valid outside IDLE is ignored; upstream must hold it.
- Reset, including mid-BUSY or in DONE:
  - Next state IDLE; W=0; state_out=0; out_valid=0; fault=0; cnt=0.
  - In-flight block discarded; in_ready=1 in the first cycle after rst deasserts.

## Timing
- Accept on edge k (in_valid & in_ready).
- Chunks processed on edges k+1..k+N.
- out_valid high from edge k+N; latency N cycles (4 with LANES=4).
- Output transfer on edge m (out_valid & out_ready) returns to IDLE; next accept is possible no earlier than edge m+1.
- Minimum block period N+2 cycles.
- Outputs registered or decoded from state only; no combinational path from in_valid/out_ready to in_ready/out_valid.

## Configuration
- INV_SBOX_FAULT_CHECK_EN defined:
  - Per lane, a forward S-box maps each new byte back.
  - Any lane mismatch against the pre-substitution byte sets fault (sticky until next accept).
  - Adds LANES forward S-box instances.
- INV_SBOX_FAULT_CHECK_EN undefined: no check logic; fault constant 0. Data timing is identical in both builds.

## Test plan
- Reset, then 128'h637c777bf26b6fc53001672bfed7ab76 -> state_out 128'h000102030405060708090a0b0c0d0e0f, out_valid exactly 4 cycles after accept, fault=0.
- All-bytes 8'h00 -> all 8'h52; all 8'h16 -> all 8'hff; all 8'hed -> all 8'h53.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> state_out/out_valid stable, in_ready=0, extra in_valid ignored; release -> IDLE next cycle.
- Assert rst during BUSY cycle 2 -> next cycle out_valid=0, state_out=0, in_ready=1; next block processes correctly.
- Sweep LANES=1,2,16 with the first vector -> latency 16, 8, 1 cycles; identical result.
- With INV_SBOX_FAULT_CHECK_EN, force one lane output bit flip -> fault=1 with out_valid; next clean block -> fault=0.
